alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage responder for ALU command traffic. Accepts one command (alu_cmd, inA, inB, sc_i)
//  over a valid/ready request channel, computes it and returns rslt plus flags over a valid/ready
//  response channel. Logic ops finish in one cycle; shifts iterate one bit per cycle. Sits between
//  the decode/issue logic and register-file writeback.
// PARAMETERS
//  WIDTH    8  datapath width in bits
//  SHAMT_W  4  bits of inB used as shift amount
// PORTS
//  clk        input   1      clock; all state updates on rising edge
//  reset      input   1      synchronous, active-high reset
//  in_valid   input   1      request valid
//  in_ready   output  1      request accepted when in_valid && in_ready at a rising edge
//  alu_cmd    input   4      opcode
//  inA        input   WIDTH  operand A
//  inB        input   WIDTH  operand B / immediate / shift amount
//  sc_i       input   1      carry-in / shift-in bit
//  out_valid  output  1      response valid
//  out_ready  input   1      response consumed when out_valid && out_ready at a rising edge
//  rslt       output  WIDTH  result
//  sc_o       output  1      carry-out / last bit shifted out
//  pari       output  1      ^rslt
//  zero       output  1      rslt == 0
//  cond       output  1      branch/compare outcome
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; out_valid=0; rslt=0; sc_o=0; pari=0; zero=1; cond=0.
//    Reset mid-operation drops the in-flight command; no response is produced for it.
//  - FSM: IDLE -> (accept, non-shift) DONE; IDLE -> (accept, shift, amt>0) SHIFT;
//    IDLE -> (accept, shift, amt==0) DONE; SHIFT -> (count reaches 0) DONE;
//    DONE -> (out_ready) IDLE. in_ready = (state==IDLE). Operands are latched on accept;
//    input changes after acceptance have no effect.
//  - Opcodes (A,B = latched operands):
//    0000 add, 0111 addi: {sc_o,rslt} = A + B + sc_i (WIDTH+1-bit sum)
//    0001 shl: shift A left amt times; each step LSB <= sc_i, sc_o <= bit shifted out
//    0010 shr: shift A right amt times; each step MSB <= sc_i, sc_o <= bit shifted out
//    0011 mov, 1010 movi: rslt = A
//    0100 or / 0101 xor / 0110 and: bitwise A op B
//    1000 bne: cond = (A != B); 1001 beq: cond = (A == B); 1101 cmp: cond = (A < B) unsigned;
//      rslt = 0 for these three
//    all other codes (incl. 1111 nop): rslt = 0, cond = 0
//  - amt = B[SHAMT_W-1:0], saturated to WIDTH (amt >= WIDTH runs WIDTH steps).
//    amt==0: rslt = A, sc_o = 0.
//  - sc_o = 0 and cond = 0 for ops that do not define them; pari and zero are always
//    derived from the final rslt.
//  - Latency, accept edge to out_valid high: 1 cycle non-shift; 1 + min(amt,WIDTH) cycles shift.
//  - Response outputs are held stable while out_valid && !out_ready (backpressure).
//    out_valid drops the cycle after the consuming edge.
//  - in_ready is low in SHIFT and DONE. A new request is accepted no earlier than the cycle
//    after the response is consumed, so at most one command is outstanding.
// TESTING
//  1. add A=1 B=2 sc_i=0 -> 1 cycle later out_valid=1, rslt=3, sc_o=0, zero=0, pari=0.
//  2. add A=8'hFF B=1 sc_i=0 -> rslt=0, sc_o=1, zero=1.
//  3. shl A=8'h81 B=3 sc_i=0 -> out_valid 4 cycles after accept, rslt=8'h08, sc_o=0;
//     shr A=4 B=1 -> rslt=2 after 2 cycles.
//  4. bne A=1 B=2 -> cond=1; beq A=1 B=1 -> cond=1; cmp A=1 B=1 -> cond=0; rslt=0 for all three.
//  5. xor A=12 B=2 with out_ready=0 for 5 cycles -> rslt=14 held stable, in_ready=0 throughout;
//     out_ready=1 -> next cycle out_valid=0, in_ready=1.
//  6. shl A=1 B=7 accepted, reset pulsed on 3rd SHIFT cycle -> next cycle out_valid=0,
//     rslt=0, zero=1, in_ready=1; no response is ever emitted for that command.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU responder with valid/ready request and response channels.
// Logic ops complete in one cycle; shifts step one bit per cycle before the response is posted.
module alu_exec_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic             sc_o,
    output logic             pari,
    output logic             zero,
    output logic             cond
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SHL  = 4'b0001;
    localparam logic [3:0] OP_SHR  = 4'b0010;
    localparam logic [3:0] OP_MOV  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_MOVI = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1101;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, rslt_q, rslt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sci_q, sci_d, shc_q, shc_d;
    logic             out_valid_q, out_valid_d, sc_o_q, sc_o_d, cond_q, cond_d;
    logic [CW-1:0]    amt;
    logic             in_shift;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_r;
    logic             res_c, res_cond;

    // Shift amount saturates at WIDTH: further steps would only repeat the fill bit.
    assign amt      = (32'(inB[SHAMT_W-1:0]) >= WIDTH) ? CW'(WIDTH) : CW'(inB[SHAMT_W-1:0]);
    assign in_shift = (alu_cmd == OP_SHL) || (alu_cmd == OP_SHR);
    assign sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, sci_q};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign rslt      = rslt_q;
    assign sc_o      = sc_o_q;
    assign cond      = cond_q;
    assign pari      = ^rslt_q;
    assign zero      = (rslt_q == '0);

    always_comb begin
        res_r    = '0;
        res_c    = 1'b0;
        res_cond = 1'b0;
        case (cmd_q)
            OP_ADD, OP_ADDI: {res_c, res_r} = sum;
            OP_SHL, OP_SHR: begin
                res_r = sh_q;
                res_c = shc_q;
            end
            OP_MOV, OP_MOVI: res_r = a_q;
            OP_OR:           res_r = a_q | b_q;
            OP_XOR:          res_r = a_q ^ b_q;
            OP_AND:          res_r = a_q & b_q;
            OP_BNE:          res_cond = (a_q != b_q);
            OP_BEQ:          res_cond = (a_q == b_q);
            OP_CMP:          res_cond = (a_q < b_q);
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        a_d         = a_q;
        b_d         = b_q;
        sci_d       = sci_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        shc_d       = shc_q;
        out_valid_d = out_valid_q;
        rslt_d      = rslt_q;
        sc_o_d      = sc_o_q;
        cond_d      = cond_q;
        case (state_q)
            IDLE: if (in_valid) begin
                cmd_d   = alu_cmd;
                a_d     = inA;
                b_d     = inB;
                sci_d   = sc_i;
                sh_d    = inA;
                shc_d   = 1'b0;
                cnt_d   = amt;
                state_d = (in_shift && amt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                sh_d    = (cmd_q == OP_SHL) ? {sh_q[WIDTH-2:0], sci_q} : {sci_q, sh_q[WIDTH-1:1]};
                shc_d   = (cmd_q == OP_SHL) ? sh_q[WIDTH-1] : sh_q[0];
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
            end
            DONE: if (!out_valid_q) begin
                out_valid_d = 1'b1;
                rslt_d      = res_r;
                sc_o_d      = res_c;
                cond_d      = res_cond;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sci_q       <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            shc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            rslt_q      <= '0;
            sc_o_q      <= 1'b0;
            cond_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sci_q       <= sci_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            shc_q       <= shc_d;
            out_valid_q <= out_valid_d;
            rslt_q      <= rslt_d;
            sc_o_q      <= sc_o_d;
            cond_q      <= cond_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against an arithmetic model.
// The model predicts each response and its latency; a negedge process compares every cycle.
module tb_alu_exec_unit;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, sc_i, out_valid, out_ready, sc_o, pari, zero, cond;
    logic [3:0] alu_cmd;
    logic [7:0] inA, inB, rslt;
    int         tests = 0;
    int         fails = 0;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       cd;
        logic [31:0] lat;
    } res_t;

    res_t m, p;
    logic m_ready = 1'b1, m_valid = 1'b0, m_fresh = 1'b1;
    int   m_age = 0;

    alu_exec_unit #(.WIDTH(8), .SHAMT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
        .out_valid(out_valid), .out_ready(out_ready), .rslt(rslt),
        .sc_o(sc_o), .pari(pari), .zero(zero), .cond(cond)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, input logic s);
        int n, av, bv, t;
        res_t o;
        av = int'(a);
        bv = int'(b);
        n = int'(b[3:0]);
        if (n > 8) n = 8;
        o = '0;
        o.lat = 1;
        case (c)
            4'd0, 4'd7: begin t = av + bv + int'(s); o.r = t[7:0]; o.c = t[8]; end
            4'd1: begin
                o.lat = 32'(1 + n);
                if (n > 0) begin t = (av << n) | (s ? (1 << n) - 1 : 0); o.r = t[7:0]; o.c = t[8]; end
                else o.r = a;
            end
            4'd2: begin
                o.lat = 32'(1 + n);
                if (n > 0) begin
                    t = (av >> n) | (s ? (255 & ~(255 >> n)) : 0);
                    o.r = t[7:0];
                    t = av >> (n - 1);
                    o.c = t[0];
                end else o.r = a;
            end
            4'd3, 4'd10: o.r = a;
            4'd4: o.r = a | b;
            4'd5: o.r = a ^ b;
            4'd6: o.r = a & b;
            4'd8: o.cd = (a != b);
            4'd9: o.cd = (a == b);
            4'd13: o.cd = (a < b);
            default: ;
        endcase
        return o;
    endfunction

    // Cycle-level protocol model: one outstanding command, response after its latency.
    always @(posedge clk) begin
        if (reset) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_fresh <= 1'b1;
            m <= '0;
        end else if (m_ready && in_valid) begin
            p <= model(alu_cmd, inA, inB, sc_i);
            m_age <= 0;
            m_ready <= 1'b0;
        end else if (!m_ready && !m_valid) begin
            if (32'(m_age + 1) == p.lat) begin
                m_valid <= 1'b1;
                m_fresh <= 1'b0;
                m <= p;
            end
            m_age <= m_age + 1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_valid);
        if (m_valid || m_fresh) begin
            chk("rslt", rslt, m.r);
            chk("sc_o", sc_o, m.c);
            chk("cond", cond, m.cd);
            chk("pari", pari, ^m.r);
            chk("zero", zero, m.r == 8'd0);
        end
    end

    task automatic garbage();
        in_valid = 1'($urandom);
        alu_cmd  = 4'($urandom);
        inA      = 8'($urandom);
        inB      = 8'($urandom);
        sc_i     = 1'($urandom);
    endtask

    task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, input logic s);
        int k = 0;
        in_valid = 1'b0;
        while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk("send_ready", in_ready, 1);
        alu_cmd = c; inA = a; inB = b; sc_i = s; in_valid = 1'b1;
        @(posedge clk); #1;
        garbage();
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; garbage(); end
        chk("resp_seen", out_valid, 1);
    endtask

    task automatic hold(input int n);
        out_ready = 1'b0;
        repeat (n) begin @(posedge clk); #1; garbage(); end
    endtask

    task automatic consume();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_cmd = '0; inA = '0; inB = '0; sc_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rslt", rslt, 0);
        chk("rst_zero", zero, 1);
        chk("rst_pari", pari, 0);
        chk("rst_sc_o", sc_o, 0);
        chk("rst_cond", cond, 0);
        reset = 1'b0;
        #0 chk("rst_in_ready", in_ready, 1);

        send(4'b0000, 8'd1, 8'd2, 1'b0); wait_resp(lat);
        chk("t1_lat", lat, 1); chk("t1_rslt", rslt, 3); chk("t1_sc_o", sc_o, 0);
        chk("t1_zero", zero, 0); chk("t1_pari", pari, 0);
        consume();

        send(4'b0000, 8'hFF, 8'd1, 1'b0); wait_resp(lat);
        chk("t2_rslt", rslt, 0); chk("t2_sc_o", sc_o, 1); chk("t2_zero", zero, 1);
        consume();

        send(4'b0001, 8'h81, 8'd3, 1'b0); wait_resp(lat);
        chk("t3_lat", lat, 4); chk("t3_rslt", rslt, 8'h08); chk("t3_sc_o", sc_o, 0);
        consume();
        send(4'b0010, 8'd4, 8'd1, 1'b0); wait_resp(lat);
        chk("t3b_lat", lat, 2); chk("t3b_rslt", rslt, 2);
        consume();

        send(4'b1000, 8'd1, 8'd2, 1'b0); wait_resp(lat);
        chk("t4_bne", cond, 1); chk("t4_bne_r", rslt, 0); consume();
        send(4'b1001, 8'd1, 8'd1, 1'b0); wait_resp(lat);
        chk("t4_beq", cond, 1); chk("t4_beq_r", rslt, 0); consume();
        send(4'b1101, 8'd1, 8'd1, 1'b0); wait_resp(lat);
        chk("t4_cmp", cond, 0); chk("t4_cmp_r", rslt, 0); consume();

        send(4'b0101, 8'd12, 8'd2, 1'b0); wait_resp(lat);
        hold(5);
        chk("t5_rslt", rslt, 14); chk("t5_in_ready", in_ready, 0); chk("t5_valid", out_valid, 1);
        consume();
        chk("t5_drop", out_valid, 0); chk("t5_ready", in_ready, 1);

        send(4'b0001, 8'd1, 8'd7, 1'b0);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        pulse_reset();
        chk("t6_valid", out_valid, 0); chk("t6_rslt", rslt, 0);
        chk("t6_zero", zero, 1); chk("t6_ready", in_ready, 1);
        repeat (12) begin
            @(posedge clk); #1;
            chk("t6_no_resp", out_valid, 0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(c, 8'($urandom), ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom),
                 1'($urandom));
            if ($urandom_range(0, 29) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                pulse_reset();
            end else begin
                wait_resp(lat);
                hold($urandom_range(0, 3));
                consume();
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
